// File: rtl/ofifo_pkg.sv
// Shared constants for the output FIFO that re-aligns skewed MAC-array column
// outputs into full rows for sfp.
//
// Contents:
//   OFIFO_BW, OFIFO_COL, OFIFO_DEPTH : default partial-sum width, column count, depth
//   ofifo_ptr_w()                    : pointer width for a given depth (address bits + wrap bit)
//   OFIFO_PTR_W                      : pointer width for the default depth
package ofifo_pkg;

  localparam int unsigned OFIFO_BW    = 16;
  localparam int unsigned OFIFO_COL   = 8;
  localparam int unsigned OFIFO_DEPTH = 64;

  // One extra MSB beyond the address bits distinguishes full from empty.
  function automatic int unsigned ofifo_ptr_w(input int unsigned d);
    return $clog2(d) + 1;
  endfunction

  localparam int unsigned OFIFO_PTR_W = ofifo_ptr_w(OFIFO_DEPTH);

endpackage

// File: rtl/fifo_col.sv
// Single-column FIFO used by ofifo. Stores partial sums from one MAC-array
// column and exposes the oldest entry combinationally for the row register.
//
// Ports:
//   clk, reset_n : rising-edge clock, asynchronous active-low reset
//   wr, din      : write strobe and data; a write to a full column is dropped
//   pop          : advance the read pointer (caller guarantees non-empty)
//   dout         : entry at the read pointer
//   empty, full  : occupancy flags from the pre-edge pointers
module fifo_col
  import ofifo_pkg::*;
#(
  parameter int unsigned bw    = OFIFO_BW,
  parameter int unsigned depth = OFIFO_DEPTH
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr,
  input  logic [bw-1:0] din,
  input  logic          pop,
  output logic [bw-1:0] dout,
  output logic          empty,
  output logic          full
);

  localparam int unsigned PtrW  = ofifo_ptr_w(depth);
  localparam int unsigned AddrW = PtrW - 1;

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [bw-1:0]   mem_q [depth];
  logic            wr_en, rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
                 (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);

  // Full is judged before the edge, so a same-edge pop never admits a write.
  assign wr_en = wr && !full;
  assign rd_en = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage is not reset; stale entries are never visible past the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AddrW-1:0]] <= din;
  end

  assign dout = mem_q[rd_ptr_q[AddrW-1:0]];

endmodule

// File: rtl/ofifo.sv
// Output FIFO between the MAC array and sfp. One FIFO per column absorbs the
// skewed column drains; a row is released only when every column holds data.
//
// Ports:
//   clk, reset_n : rising-edge clock, asynchronous active-low reset
//   wr           : per-column write strobe
//   in           : column i data on in[bw*i +: bw]
//   rd           : pop one full row (ignored while !o_valid)
//   out          : registered popped row, same column order as in
//   o_valid      : every column non-empty
//   o_full       : any column full
//   o_ready      : !o_full
//   o_overflow   : sticky write-to-full flag
//
// Build option: define OFIFO_OVF_DET_EN to enable overflow detection;
// otherwise o_overflow is tied low.
module ofifo
  import ofifo_pkg::*;
#(
  parameter int unsigned bw    = OFIFO_BW,
  parameter int unsigned col   = OFIFO_COL,
  parameter int unsigned depth = OFIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [col-1:0]    wr,
  input  logic [bw*col-1:0] in,
  input  logic              rd,
  output logic [bw*col-1:0] out,
  output logic              o_valid,
  output logic              o_full,
  output logic              o_ready,
  output logic              o_overflow
);

  logic [col-1:0]    empty_vec, full_vec;
  logic [bw*col-1:0] rd_row;
  logic              pop;

  assign o_valid = ~|empty_vec;
  assign o_full  = |full_vec;
  assign o_ready = !o_full;
  assign pop     = rd && o_valid;

  for (genvar i = 0; i < col; i++) begin : g_col
    fifo_col #(
      .bw    (bw),
      .depth (depth)
    ) u_col (
      .clk     (clk),
      .reset_n (reset_n),
      .wr      (wr[i]),
      .din     (in[bw*i +: bw]),
      .pop     (pop),
      .dout    (rd_row[bw*i +: bw]),
      .empty   (empty_vec[i]),
      .full    (full_vec[i])
    );
  end

  // Row register holds its value when no pop happens.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out <= '0;
    end else if (pop) begin
      out <= rd_row;
    end
  end

`ifdef OFIFO_OVF_DET_EN
  logic overflow_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (|(wr & full_vec)) begin
      overflow_q <= 1'b1;
    end
  end

  assign o_overflow = overflow_q;
`else
  assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ofifo.sv
// Self-checking bench for ofifo (bw=16, col=8, depth=64). Stimulus pushes the
// expected row into a scoreboard queue whenever it issues a pop the model
// accepts; a monitor compares out one cycle after each accepted pop.
module tb_ofifo;

  localparam int BW = 16;
  localparam int COL = 8;
  localparam int DEPTH = 64;
  localparam int RW = BW * COL;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [COL-1:0] wr = '0;
  logic [RW-1:0] din = '0;
  logic          rd = 1'b0;
  logic [RW-1:0] dout;
  logic          o_valid, o_full, o_ready, o_overflow;

  int checks = 0;
  int errors = 0;

  // Reference model: count-based circular buffer per column.
  logic [BW-1:0] mmem [COL][DEPTH];
  int            mhead [COL];
  int            mcnt  [COL];
  bit            movf;
  logic [RW-1:0] sbq [$];
  logic [RW-1:0] mon_exp;

  ofifo #(
    .bw    (BW),
    .col   (COL),
    .depth (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr         (wr),
    .in         (din),
    .rd         (rd),
    .out        (dout),
    .o_valid    (o_valid),
    .o_full     (o_full),
    .o_ready    (o_ready),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [RW-1:0] rep(input logic [BW-1:0] v);
    return {COL{v}};
  endfunction

  function automatic logic exp_ovf();
`ifdef OFIFO_OVF_DET_EN
    return movf;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int c = 0; c < COL; c++) begin
      mhead[c] = 0;
      mcnt[c]  = 0;
    end
    movf = 1'b0;
  endtask

  task automatic check_flags();
    logic ev, ef;
    ev = 1'b1;
    ef = 1'b0;
    for (int c = 0; c < COL; c++) begin
      if (mcnt[c] == 0) ev = 1'b0;
      if (mcnt[c] == DEPTH) ef = 1'b1;
    end
    chk("o_valid", RW'(o_valid), RW'(ev));
    chk("o_full", RW'(o_full), RW'(ef));
    chk("o_ready", RW'(o_ready), RW'(!ef));
    chk("o_overflow", RW'(o_overflow), RW'(exp_ovf()));
  endtask

  task automatic model_step(input logic [COL-1:0] w, input logic [RW-1:0] d, input logic r);
    logic          v, wdone;
    logic [RW-1:0] row;
    v = 1'b1;
    for (int c = 0; c < COL; c++) if (mcnt[c] == 0) v = 1'b0;
    if (r && v) begin
      for (int c = 0; c < COL; c++) row[BW*c +: BW] = mmem[c][mhead[c]];
      sbq.push_back(row);
    end
    for (int c = 0; c < COL; c++) begin
      wdone = w[c] && (mcnt[c] < DEPTH);
      if (w[c] && mcnt[c] == DEPTH) movf = 1'b1;
      if (wdone) mmem[c][(mhead[c] + mcnt[c]) % DEPTH] = d[BW*c +: BW];
      if (r && v) begin
        mhead[c] = (mhead[c] + 1) % DEPTH;
        mcnt[c]--;
      end
      if (wdone) mcnt[c]++;
    end
  endtask

  // One cycle: check flags from the previous edge, then drive the next edge.
  task automatic cyc(input logic [COL-1:0] w, input logic [RW-1:0] d, input logic r);
    @(negedge clk);
    check_flags();
    wr  = w;
    din = d;
    rd  = r;
    model_step(w, d, r);
  endtask

  // Monitor: every accepted pop must show the expected row one cycle later.
  always @(posedge clk) begin
    if (reset_n && rd && o_valid) begin
      #2;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL row: got %h expected no pop at %0t", dout, $time);
      end else begin
        mon_exp = sbq.pop_front();
        chk("row", dout, mon_exp);
      end
    end
  end

  initial begin
    logic [RW-1:0] d;
    model_reset();

    // Reset and idle
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out", dout, '0);
    check_flags();
    reset_n = 1'b1;

    // Skewed fill: column i writes 0x0100+i at cycle i
    for (int i = 0; i < COL; i++) begin
      d = '0;
      d[BW*i +: BW] = 16'h0100 + 16'(i);
      cyc(COL'(1) << i, d, 1'b0);
    end
    cyc('0, '0, 1'b0);
    chk("skew_valid", RW'(o_valid), RW'(1));
    cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b0);
    chk("skew_row", dout, 128'h0107_0106_0105_0104_0103_0102_0101_0100);

    // Mid-cycle asynchronous reset with data held
    cyc('1, rep(16'hAAAA), 1'b0);
    cyc('0, '0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out", dout, '0);
    chk("mid_rst_valid", RW'(o_valid), RW'(0));
    chk("mid_rst_ready", RW'(o_ready), RW'(1));
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Fill column 0 alone, then a dropped 65th write
    for (int k = 0; k < DEPTH; k++) cyc(8'h01, RW'(k), 1'b0);
    cyc('0, '0, 1'b0);
    chk("c0_full", RW'(o_full), RW'(1));
    chk("c0_ready", RW'(o_ready), RW'(0));
    chk("c0_valid", RW'(o_valid), RW'(0));
    cyc(8'h01, RW'(16'h0BAD), 1'b0);
    cyc('0, '0, 1'b0);
`ifdef OFIFO_OVF_DET_EN
    chk("ovf_set", RW'(o_overflow), RW'(1));
`else
    chk("ovf_tied", RW'(o_overflow), RW'(0));
`endif

    // Fill the rest, then pop a full FIFO while writing to it
    for (int k = 0; k < DEPTH; k++) cyc(8'hFE, rep(16'h1000 + 16'(k)), 1'b0);
    cyc(8'hFF, rep(16'hDEAD), 1'b1);
    for (int k = 1; k < DEPTH; k++) cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b0);
    chk("drain_valid", RW'(o_valid), RW'(0));
`ifdef OFIFO_OVF_DET_EN
    chk("ovf_sticky", RW'(o_overflow), RW'(1));
`endif

    // rd while empty holds out and leaves pointers alone
    cyc(8'hFF, rep(16'hFFFF), 1'b0);
    cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b0);
    chk("empty_rd_hold", dout, {8{16'hFFFF}});
    cyc(8'hFF, rep(16'h0001), 1'b0);
    cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b0);
    chk("after_empty_rd", dout, {8{16'h0001}});

    // Steady stream: write k each cycle with rd held high
    for (int k = 1; k <= 20; k++) cyc(8'hFF, rep(16'(k)), 1'b1);
    cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b0);
    chk("stream_last", dout, rep(16'd20));

    // Wrap-around: 200 rows -100..99, occupancy builds to 30 then streams
    for (int r = 0; r < 200; r++) cyc(8'hFF, rep(16'(r - 100)), r >= 30);
    for (int k = 0; k < 30; k++) cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b0);
    chk("wrap_last", dout, rep(16'd99));
    cyc('0, '0, 1'b0);

    chk("sb_drain", RW'(sbq.size()), RW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
